// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: captures ALU {N,V,Z} flags, evaluates conditional
// branches against them and, on a taken branch, issues a single-cycle PC
// redirect followed by a fixed-length pipeline flush.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | ready to accept a branch; a taken branch starts the flush window
//  FLUSH | younger instructions squashed; fcnt counts down the window length
module branch_resolve_unit #(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int BYPASS       = 1,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_we,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_negative,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic [2:0]        flags_q,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          fcnt_q, fcnt_d;
    logic [2:0]          flag_reg_q, flag_reg_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]    taken_count_q, taken_count_d;

    logic [2:0]          eff_flags;
    logic                eff_n, eff_v, eff_z;
    logic                cond_true;
    logic                accept;

    // Flag source for evaluation: forward live ALU flags when bypassing.
    always_comb begin
        eff_flags = flag_reg_q;
        if ((BYPASS != 0) && flag_we) begin
            eff_flags = {alu_negative, alu_overflow, alu_zero};
        end
        eff_n = eff_flags[2];
        eff_v = eff_flags[1];
        eff_z = eff_flags[0];
    end

    // Condition code decode against the effective flags.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = eff_z;
            3'b010:  cond_true = ~eff_z;
            3'b011:  cond_true = eff_n ^ eff_v;
            3'b100:  cond_true = ~(eff_n ^ eff_v);
            3'b101:  cond_true = eff_n;
            3'b110:  cond_true = eff_v;
            default: cond_true = 1'b0;
        endcase
    end

    // Without bypass a same-cycle flag write would race the evaluation, so stall.
    assign br_ready = (state_q == IDLE) && !((BYPASS == 0) && flag_we);
    assign accept   = br_valid && br_ready;

    // Next-state, flag capture, redirect and counter update.
    always_comb begin
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        flag_reg_d       = flag_reg_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        taken_count_d    = taken_count_q;

        if (flag_we) begin
            flag_reg_d = {alu_negative, alu_overflow, alu_zero};
        end

        case (state_q)
            IDLE: begin
                if (accept && cond_true) begin
                    state_d          = FLUSH;
                    fcnt_d           = 4'(FLUSH_CYCLES - 1);
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = br_target;
                    if (taken_count_q != {CNT_W{1'b1}}) begin
                        taken_count_d = taken_count_q + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            fcnt_q           <= 4'd0;
            flag_reg_q       <= 3'b000;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            taken_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            flag_reg_q       <= flag_reg_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign flags_q        = flag_reg_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = (state_q == FLUSH);
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: three instances (default, BYPASS=0, CNT_W=2) share clk/reset.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        few  [3];
    logic        az   [3];
    logic        av   [3];
    logic        an   [3];
    logic        bv   [3];
    logic [2:0]  bc   [3];
    logic [15:0] bt   [3];
    logic        rdy  [3];
    logic        rv   [3];
    logic [15:0] rpc  [3];
    logic        fl   [3];
    logic [2:0]  flg  [3];
    logic [7:0]  tc0, tc1;
    logic [1:0]  tc2;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.ADDR_W(16), .FLUSH_CYCLES(2), .BYPASS(1), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .flag_we(few[0]), .alu_zero(az[0]),
        .alu_overflow(av[0]), .alu_negative(an[0]), .br_valid(bv[0]),
        .br_cond(bc[0]), .br_target(bt[0]), .br_ready(rdy[0]),
        .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .flush(fl[0]),
        .flags_q(flg[0]), .taken_count(tc0));

    branch_resolve_unit #(.ADDR_W(16), .FLUSH_CYCLES(2), .BYPASS(0), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .flag_we(few[1]), .alu_zero(az[1]),
        .alu_overflow(av[1]), .alu_negative(an[1]), .br_valid(bv[1]),
        .br_cond(bc[1]), .br_target(bt[1]), .br_ready(rdy[1]),
        .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .flush(fl[1]),
        .flags_q(flg[1]), .taken_count(tc1));

    branch_resolve_unit #(.ADDR_W(16), .FLUSH_CYCLES(2), .BYPASS(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flag_we(few[2]), .alu_zero(az[2]),
        .alu_overflow(av[2]), .alu_negative(an[2]), .br_valid(bv[2]),
        .br_cond(bc[2]), .br_target(bt[2]), .br_ready(rdy[2]),
        .redirect_valid(rv[2]), .redirect_pc(rpc[2]), .flush(fl[2]),
        .flags_q(flg[2]), .taken_count(tc2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write flags on dut0 for one cycle.
    task automatic set_flags0(input logic n, input logic v, input logic z);
        few[0] = 1'b1; an[0] = n; av[0] = v; az[0] = z;
        tick();
        few[0] = 1'b0;
    endtask

    // Present one branch on dut0 and check the outcome.
    task automatic br_try0(input string tag, input logic [2:0] cond,
                           input logic [15:0] tgt, input logic exp_taken);
        bv[0] = 1'b1; bc[0] = cond; bt[0] = tgt;
        #1;
        chk({tag, "_ready"}, 32'(rdy[0]), 32'(1'b1));
        tick();
        bv[0] = 1'b0;
        chk({tag, "_rv"}, 32'(rv[0]), 32'(exp_taken));
        chk({tag, "_flush"}, 32'(fl[0]), 32'(exp_taken));
        if (exp_taken) begin
            chk({tag, "_pc"}, 32'(rpc[0]), 32'(tgt));
            tick();
            tick();
            chk({tag, "_flush_end"}, 32'(fl[0]), 32'(1'b0));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            few[i] = 0; az[i] = 0; av[i] = 0; an[i] = 0;
            bv[i] = 0; bc[i] = 3'b000; bt[i] = 16'h0000;
        end
        reset = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_flags", 32'(flg[0]), 32'h0);
        chk("rst_rv", 32'(rv[0]), 32'h0);
        chk("rst_pc", 32'(rpc[0]), 32'h0);
        chk("rst_flush", 32'(fl[0]), 32'h0);
        chk("rst_cnt", 32'(tc0), 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'h1);

        // Flag capture N=1
        set_flags0(1'b1, 1'b0, 1'b0);
        chk("flag_n", 32'(flg[0]), 32'h4);

        // EQ taken from registered Z
        set_flags0(1'b0, 1'b0, 1'b1);
        chk("flag_z", 32'(flg[0]), 32'h1);
        bv[0] = 1'b1; bc[0] = 3'b001; bt[0] = 16'h0040;
        #1;
        chk("eq_ready", 32'(rdy[0]), 32'h1);
        tick();
        bv[0] = 1'b0;
        chk("eq_rv", 32'(rv[0]), 32'h1);
        chk("eq_pc", 32'(rpc[0]), 32'h0040);
        chk("eq_flush1", 32'(fl[0]), 32'h1);
        chk("eq_rdy1", 32'(rdy[0]), 32'h0);
        chk("eq_cnt", 32'(tc0), 32'h1);
        tick();
        chk("eq_rv_off", 32'(rv[0]), 32'h0);
        chk("eq_flush2", 32'(fl[0]), 32'h1);
        chk("eq_rdy2", 32'(rdy[0]), 32'h0);
        chk("eq_pc_hold", 32'(rpc[0]), 32'h0040);
        tick();
        chk("eq_flush3", 32'(fl[0]), 32'h0);
        chk("eq_rdy3", 32'(rdy[0]), 32'h1);

        // Bypass: same-cycle Z forwarded
        set_flags0(1'b0, 1'b0, 1'b0);
        chk("byp_flag0", 32'(flg[0]), 32'h0);
        few[0] = 1'b1; az[0] = 1'b1;
        bv[0] = 1'b1; bc[0] = 3'b001; bt[0] = 16'h0080;
        #1;
        chk("byp_ready", 32'(rdy[0]), 32'h1);
        tick();
        few[0] = 1'b0; az[0] = 1'b0; bv[0] = 1'b0;
        chk("byp_rv", 32'(rv[0]), 32'h1);
        chk("byp_pc", 32'(rpc[0]), 32'h0080);
        chk("byp_flag", 32'(flg[0]), 32'h1);
        chk("byp_cnt", 32'(tc0), 32'h2);
        tick();
        tick();

        // No bypass: stall one cycle, then accept
        few[1] = 1'b1; az[1] = 1'b1;
        bv[1] = 1'b1; bc[1] = 3'b001; bt[1] = 16'h00C0;
        #1;
        chk("nob_ready0", 32'(rdy[1]), 32'h0);
        tick();
        few[1] = 1'b0; az[1] = 1'b0;
        chk("nob_rv0", 32'(rv[1]), 32'h0);
        chk("nob_flush0", 32'(fl[1]), 32'h0);
        chk("nob_flag", 32'(flg[1]), 32'h1);
        #1;
        chk("nob_ready1", 32'(rdy[1]), 32'h1);
        tick();
        bv[1] = 1'b0;
        chk("nob_rv1", 32'(rv[1]), 32'h1);
        chk("nob_pc", 32'(rpc[1]), 32'h00C0);
        chk("nob_cnt", 32'(tc1), 32'h1);
        tick();
        tick();
        chk("nob_flush_end", 32'(fl[1]), 32'h0);

        // LT / GE sweep over {N,V}
        set_flags0(1'b0, 1'b0, 1'b0);
        br_try0("lt00", 3'b011, 16'h1000, 1'b0);
        br_try0("ge00", 3'b100, 16'h1004, 1'b1);
        set_flags0(1'b0, 1'b1, 1'b0);
        br_try0("lt01", 3'b011, 16'h1008, 1'b1);
        br_try0("ge01", 3'b100, 16'h100C, 1'b0);
        set_flags0(1'b1, 1'b0, 1'b0);
        br_try0("lt10", 3'b011, 16'h1010, 1'b1);
        br_try0("ge10", 3'b100, 16'h1014, 1'b0);
        set_flags0(1'b1, 1'b1, 1'b0);
        br_try0("lt11", 3'b011, 16'h1018, 1'b0);
        br_try0("ge11", 3'b100, 16'h101C, 1'b1);
        br_try0("al", 3'b000, 16'h2000, 1'b1);
        br_try0("nv", 3'b111, 16'h3000, 1'b0);
        chk("nv_pc_hold", 32'(rpc[0]), 32'h2000);
        set_flags0(1'b0, 1'b0, 1'b1);
        br_try0("ne_z1", 3'b010, 16'h4000, 1'b0);
        chk("sweep_cnt", 32'(tc0), 32'h7);

        // Reset during second flush cycle
        bv[0] = 1'b1; bc[0] = 3'b000; bt[0] = 16'h0100;
        tick();
        bv[0] = 1'b0;
        chk("rmf_flush1", 32'(fl[0]), 32'h1);
        tick();
        chk("rmf_flush2", 32'(fl[0]), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rmf_flush", 32'(fl[0]), 32'h0);
        chk("rmf_ready", 32'(rdy[0]), 32'h1);
        chk("rmf_cnt", 32'(tc0), 32'h0);
        chk("rmf_flags", 32'(flg[0]), 32'h0);

        // Saturating counter, br_valid held through flush
        bv[2] = 1'b1; bc[2] = 3'b000; bt[2] = 16'h0200;
        tick();
        chk("sat_cnt1", 32'(tc2), 32'h1);
        chk("sat_rv1", 32'(rv[2]), 32'h1);
        tick();
        chk("sat_hold_cnt", 32'(tc2), 32'h1);
        chk("sat_hold_rdy", 32'(rdy[2]), 32'h0);
        tick();
        chk("sat_idle_flush", 32'(fl[2]), 32'h0);
        chk("sat_idle_rdy", 32'(rdy[2]), 32'h1);
        chk("sat_idle_cnt", 32'(tc2), 32'h1);
        repeat (10) tick();
        bv[2] = 1'b0;
        chk("sat_rv5", 32'(rv[2]), 32'h1);
        chk("sat_cnt", 32'(tc2), 32'h3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
